// File: rtl/vram_fetcher_pkg.sv
// vram_fetcher_pkg: shared definitions for the VRAM line fetcher.
//   VADDR_W       - SRAM byte-address width
//   fetch_state_e - fetcher FSM encoding (IDLE=0, ASIC1=1, ASIC2=2, GAP=3)
package vram_fetcher_pkg;

  localparam int unsigned VADDR_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASIC1 = 2'd1,
    ASIC2 = 2'd2,
    GAP   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vfetch_fifo.sv
// vfetch_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empty the FIFO (has priority over push/pop)
//   push, wdata - write one entry (never issued when full)
//   pop         - remove head entry; ignored while empty
//   head        - head entry, or the last popped byte while empty
//   valid       - FIFO non-empty
//   count       - current occupancy
module vfetch_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  // While empty the head shows the most recently popped byte.
  assign head   = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_fetcher.sv
// vram_fetcher: ASIC-side video reader on the time-shared SRAM port.
// Fetches BYTES_PER_LINE bytes per line_start into a pixel FIFO, taking
// two-clock ASIC slots separated by at least CPU_GAP CPU clocks.
//   clk, rst_n    - clock, asynchronous active-low reset
//   frame_start   - latch screen_base, reset line counter, flush FIFO
//   line_start    - open next display line (active if fetch_en)
//   fetch_en      - line inside display window
//   screen_base   - byte address of line 0
//   whichturn     - 1 while the ASIC owns the SRAM slot
//   vramaddr      - SRAM address for the current ASIC slot
//   data_to_asic  - SRAM read data
//   pix_rd        - serializer pop request
//   pix_data      - FIFO head byte (FWFT)
//   pix_valid     - FIFO non-empty
//   line_done     - pulse after the last byte of a line is captured
//   underrun      - sticky underrun flag
// Optional: define VFETCH_UNDERRUN_EN to enable underrun detection.
module vram_fetcher
  import vram_fetcher_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = 128,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CPU_GAP        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        fetch_en,
  input  logic [18:0] screen_base,
  output logic        whichturn,
  output logic [18:0] vramaddr,
  input  logic [7:0]  data_to_asic,
  input  logic        pix_rd,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  output logic        line_done,
  output logic        underrun
);

  localparam int unsigned LB    = $clog2(BYTES_PER_LINE);
  localparam int unsigned BI_W  = LB + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GAP_W = $clog2(CPU_GAP + 1);

  fetch_state_e         state;
  fetch_state_e         state_nxt;
  logic [VADDR_W-1:0]   base_q;
  logic [VADDR_W-1:0]   line_cnt;
  logic [BI_W-1:0]      byte_idx;
  logic                 line_active;
  logic                 first_line;
  logic                 discard;
  logic [GAP_W-1:0]     gap_cnt;
  logic [CNT_W-1:0]     fifo_count;
  logic                 abort_evt;
  logic                 slot_ok;
  logic                 capture;
  logic                 last_byte;
  logic [VADDR_W-1:0]   slot_addr;

  assign abort_evt = line_start || frame_start;
  assign last_byte = (byte_idx == BI_W'(BYTES_PER_LINE - 1));

  // No new slot is opened in a cycle that redefines the line.
  assign slot_ok = line_active && (byte_idx < BI_W'(BYTES_PER_LINE)) &&
                   (fifo_count < CNT_W'(FIFO_DEPTH)) && !abort_evt;

  // A slot aborted during ASIC1 (discard) or at the ASIC2 edge is not pushed.
  assign capture = (state == ASIC2) && line_active && !discard && !abort_evt;

  assign slot_addr = base_q + (line_cnt << LB) + VADDR_W'(byte_idx);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (slot_ok) state_nxt = ASIC1;
      ASIC1:   state_nxt = ASIC2;
      ASIC2:   state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_W'(CPU_GAP - 1)) state_nxt = slot_ok ? ASIC1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      whichturn <= 1'b0;
      vramaddr  <= '0;
      gap_cnt   <= '0;
      discard   <= 1'b0;
    end else begin
      state     <= state_nxt;
      whichturn <= (state_nxt == ASIC1) || (state_nxt == ASIC2);
      if (state_nxt == ASIC1 && state != ASIC1) vramaddr <= slot_addr;
      gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == ASIC1 && abort_evt) discard <= 1'b1;
      else if (state == ASIC2)         discard <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      line_cnt    <= '0;
      byte_idx    <= '0;
      line_active <= 1'b0;
      first_line  <= 1'b1;
      line_done   <= 1'b0;
    end else begin
      line_done <= capture && last_byte;
      if (frame_start) base_q <= screen_base;
      if (line_start) begin
        // frame_start together with line_start opens line 0.
        if (frame_start || first_line) line_cnt <= '0;
        else                           line_cnt <= line_cnt + 1'b1;
        first_line  <= 1'b0;
        byte_idx    <= '0;
        line_active <= fetch_en;
      end else if (frame_start) begin
        line_cnt    <= '0;
        first_line  <= 1'b1;
        line_active <= 1'b0;
      end else if (capture) begin
        byte_idx <= byte_idx + 1'b1;
        if (last_byte) line_active <= 1'b0;
      end
    end
  end

  vfetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (capture),
    .wdata (data_to_asic),
    .pop   (pix_rd),
    .head  (pix_data),
    .valid (pix_valid),
    .count (fifo_count)
  );

`ifdef VFETCH_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  underrun <= 1'b0;
    else if (frame_start)                        underrun <= 1'b0;
    else if (pix_rd && !pix_valid && line_active) underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif

endmodule
